dice_matrix_scan: RTL and testbench
===================================

# dice_matrix_scan

Parametrised 8×8 bi-colour dot-matrix driver for the two-dice game; successor to the fixed-rate dice display. Scans one row at a time with a programmable dwell. Latches new dice values tear-free at frame boundaries. Adds blink and a yellow "doubles" highlight. Sits between the dice roll/stop controller and the matrix pins.

## Interface
**Parameters**
- `DIV`, default 1: clk cycles each row is held; legal range ≥1.
- `BLINK_FRAMES`, default 64: frames per blink half-period; legal range ≥1.

**Ports**
- `clk`, in, 1: scan clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `load`, in, 1: one-cycle strobe; captures `dice1`/`dice2`.
- `dice1`, in, 4: die 1 value. 1–9 are valid; any other value shows blank.
- `dice2`, in, 4: die 2 value, same encoding as `dice1`.
- `blink`, in, 1: 1 = flash the columns, 0 = steady display.
- `row`, out, 8: row select, active-low, exactly one bit low while scanning.
- `r_col`, out, 8: red column drive, active-high.
- `g_col`, out, 8: green column drive, active-high.
- `frame_done`, out, 1: one-cycle pulse on the last cycle of row index 7.

## Operation
**Scan**
- Row index `idx` runs 0..7. While `idx` is shown, `row` has bit `7-idx` low and all other bits high.
- A dwell counter runs 0..`DIV-1`. `idx` advances when the counter reaches `DIV-1`. `idx` wraps 7→0; this edge is the "wrap".

**Pip patterns**
- Each die maps to 3 rows × 3 bits (p0, p1, p2):
  - 1: 000/010/000
  - 2: 001/000/100
  - 3: 100/010/001
  - 4: 101/000/101
  - 5: 101/010/101
  - 6: 111/000/111
  - 7: 111/010/111
  - 8: 111/101/111
  - 9: 111/111/111
  - other values: 000/000/000

**Column mapping**
- Die 1 (red): rows idx 0,1,2 show p0,p1,p2 on `r_col[2:0]`.
- Die 2 (green): rows idx 5,6,7 show p0,p1,p2 on `g_col[7:5]`.
- Rows idx 3 and 4 are always dark.
- Every column bit not driven by a pattern is 0.

**Doubles**
- Condition: the displayed values are equal and both lie in 1..9.
- When it holds, the die-1 pattern is also driven on `g_col[2:0]` and the die-2 pattern also on `r_col[7:5]`. Both dice then appear yellow.

**Load**
- `load` copies `dice1`/`dice2` into pending registers. The last load before a wrap wins.
- Pending values are committed to the displayed registers at the wrap.
- If `load` and the wrap fall on the same edge, the incoming values are committed directly.
- Result: no frame ever mixes old and new values.

**Blink**
- A frame counter increments at each wrap. At count `BLINK_FRAMES-1` it clears and toggles `phase`.
- With `blink`=1 and `phase`=off, `r_col`=`g_col`=0 while `row` keeps scanning.
- With `blink`=0, `phase` is held on and the frame counter is held at 0.
- Deasserting `blink` restores columns at the very next edge.

## Timing
**Outputs**
- All outputs are registered and update on the `clk` rising edge.
- Each output reflects `idx` and the displayed values as of the same edge.

**Reset (`rst`=1 at an edge)**
- `row`=8'hFF, `r_col`=0, `g_col`=0, `frame_done`=0.
- `idx`=0, dwell=0, frame counter=0, `phase`=on.
- Displayed and pending dice = 0, so the display is blank.

**Start-up and frame period**
- First edge with `rst`=0: `row`=8'b0111_1111 (idx 0).
- Frame period is 8×`DIV` cycles.
- With `DIV`=1, `row` steps one bit per cycle: 7F, BF, DF, EF, F7, FB, FD, FE, 7F…

**`frame_done`**
- High for exactly one cycle: the final dwell cycle of idx 7.
- The wrap follows on the next edge.

**Load latency**
- A load strobe sampled in frame N appears from row idx 0 of frame N+1.

**Reset mid-operation**
- Takes effect at the next edge and overrides everything.
- Pending loads are discarded.
- `rst` held high for several cycles keeps all reset values.

**Boundary conditions**
- `load` with an invalid value blanks that die at the next frame.
- Simultaneous `load` and `rst`: reset wins.
- Blink toggles only at a wrap, never mid-frame.

## Test plan
- Reset, then `DIV`=1, load 3/5: `row` sequence 7F,BF,DF,EF,F7,FB,FD,FE repeats.
  - Frame 2: `r_col`=04,02,01 on idx 0–2 and `g_col`=A0,40,A0 on idx 5–7.
  - All other column values are 0.
- `DIV`=3: each `row` value is held 3 cycles; `frame_done` is high on cycles 24, 48… after the first scanning edge.
- Load 4/4: idx 0 shows `r_col`=`g_col`=05 and idx 5 shows `r_col`=`g_col`=A0. Then load 4/6: the yellow highlight disappears from the next frame only.
- `load` of 9/9 on the cycle of idx 3, then `load` of 1/2 on idx 6: next frame shows 1/2. Also drive `load` coincident with the wrap: the loaded value is shown in that same new frame.
- `blink`=1, `BLINK_FRAMES`=2: columns stay on for 2 frames, then off for 2 frames (`row` still scanning). Drop `blink` during an off frame: columns return at the next edge.
- Assert `rst` mid-frame at idx 5: next edge gives `row`=FF and cols 0. Release: the next edge shows `row`=7F with blank columns until a new load.

Source files
------------

// File: rtl/dice_matrix_scan_if.sv
// dice_matrix_scan_if
// Groups the dice display's control inputs and matrix outputs into one bundle.
//   master : drives load/dice1/dice2/blink, observes the matrix outputs
//   slave  : the scan driver itself
// Signals:
//   load        one-cycle strobe capturing dice1/dice2
//   dice1/dice2 die values, 1..9 valid, anything else shows blank
//   blink       1 = flash the columns, 0 = steady
//   row         active-low row select
//   r_col/g_col active-high red/green column drive
//   frame_done  one-cycle pulse on the last cycle of row index 7
interface dice_matrix_scan_if;
    logic       load;
    logic [3:0] dice1;
    logic [3:0] dice2;
    logic       blink;
    logic [7:0] row;
    logic [7:0] r_col;
    logic [7:0] g_col;
    logic       frame_done;

    modport master (
        output load, dice1, dice2, blink,
        input  row, r_col, g_col, frame_done
    );

    modport slave (
        input  load, dice1, dice2, blink,
        output row, r_col, g_col, frame_done
    );
endinterface

// File: rtl/dice_matrix_scan.sv
// dice_matrix_scan
// Bi-colour 8x8 dot-matrix driver for the two-dice game. Scans one row at a
// time, holding each row for DIV clocks. New dice values are committed only at
// the frame wrap so a frame never mixes old and new values. Supports blinking
// and a yellow highlight when both dice show the same valid value.
// Parameters:
//   DIV          clk cycles each row is held (>=1)
//   BLINK_FRAMES frames per blink half-period (>=1)
// Ports:
//   clk  scan clock
//   rst  synchronous active-high reset
//   bus  dice_matrix_scan_if.slave (load, dice1, dice2, blink in;
//        row, r_col, g_col, frame_done out, all registered)
module dice_matrix_scan #(
    parameter int DIV          = 1,
    parameter int BLINK_FRAMES = 64
) (
    input logic               clk,
    input logic               rst,
    dice_matrix_scan_if.slave bus
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // ST_IDLE is only occupied straight after reset: the first edge out of
    // reset shows row 0 without advancing, and is not a frame wrap.
    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [3:0]    disp1, disp1_n, disp2, disp2_n;
    logic [3:0]    pend1, pend1_n, pend2, pend2_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          phase, phase_n;
    logic [7:0]    row_q, row_n;
    logic [7:0]    r_q, r_n;
    logic [7:0]    g_q, g_n;
    logic          fd_q, fd_n;

    logic          wrap;
    logic          dbl;
    logic [2:0]    bits;
    logic [1:0]    rel;

    // Pip pattern as {p0, p1, p2}; bit 2 of each row triple is the left dot.
    function automatic logic [8:0] pip(input logic [3:0] v);
        case (v)
            4'd1:    pip = 9'b000_010_000;
            4'd2:    pip = 9'b001_000_100;
            4'd3:    pip = 9'b100_010_001;
            4'd4:    pip = 9'b101_000_101;
            4'd5:    pip = 9'b101_010_101;
            4'd6:    pip = 9'b111_000_111;
            4'd7:    pip = 9'b111_010_111;
            4'd8:    pip = 9'b111_101_111;
            4'd9:    pip = 9'b111_111_111;
            default: pip = 9'b000_000_000;
        endcase
    endfunction

    function automatic logic [2:0] pip_row(input logic [3:0] v, input logic [1:0] r);
        logic [8:0] p;
        p = pip(v);
        case (r)
            2'd0:    pip_row = p[8:6];
            2'd1:    pip_row = p[5:3];
            default: pip_row = p[2:0];
        endcase
    endfunction

    assign wrap = (state == ST_SCAN) && (idx == 3'd7) && (dwell == DWELL_LAST);

    // Next-state and next-output computation. Outputs are derived from the
    // post-edge row index and displayed values so they register together.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        dwell_n = dwell;
        disp1_n = disp1;
        disp2_n = disp2;
        pend1_n = pend1;
        pend2_n = pend2;
        fcnt_n  = fcnt;
        phase_n = phase;
        row_n   = 8'hFF;
        r_n     = 8'h00;
        g_n     = 8'h00;
        fd_n    = 1'b0;
        dbl     = 1'b0;
        bits    = 3'b000;
        rel     = 2'd0;

        case (state)
            ST_IDLE: begin
                state_n = ST_SCAN;
                idx_n   = 3'd0;
                dwell_n = '0;
            end
            default: begin
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    idx_n   = idx + 3'd1;
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
        endcase

        if (bus.load) begin
            pend1_n = bus.dice1;
            pend2_n = bus.dice2;
        end

        // A load on the wrap edge bypasses pending and lands in the new frame.
        if (wrap) begin
            disp1_n = bus.load ? bus.dice1 : pend1;
            disp2_n = bus.load ? bus.dice2 : pend2;
        end

        if (!bus.blink) begin
            fcnt_n  = '0;
            phase_n = 1'b1;
        end else if (wrap) begin
            if (fcnt == FRAME_LAST) begin
                fcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                fcnt_n = fcnt + 1'b1;
            end
        end

        row_n = ~(8'h80 >> idx_n);
        fd_n  = (idx_n == 3'd7) && (dwell_n == DWELL_LAST);
        dbl   = (disp1_n == disp2_n) && (disp1_n >= 4'd1) && (disp1_n <= 4'd9);

        if (idx_n <= 3'd2) begin
            bits     = pip_row(disp1_n, idx_n[1:0]);
            r_n[2:0] = bits;
            if (dbl) g_n[2:0] = bits;
        end else if (idx_n >= 3'd5) begin
            rel      = 2'(idx_n - 3'd5);
            bits     = pip_row(disp2_n, rel);
            g_n[7:5] = bits;
            if (dbl) r_n[7:5] = bits;
        end

        // Blink blanks columns only; the row keeps scanning.
        if (bus.blink && !phase_n) begin
            r_n = 8'h00;
            g_n = 8'h00;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
            dwell <= '0;
            disp1 <= 4'd0;
            disp2 <= 4'd0;
            pend1 <= 4'd0;
            pend2 <= 4'd0;
            fcnt  <= '0;
            phase <= 1'b1;
            row_q <= 8'hFF;
            r_q   <= 8'h00;
            g_q   <= 8'h00;
            fd_q  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            dwell <= dwell_n;
            disp1 <= disp1_n;
            disp2 <= disp2_n;
            pend1 <= pend1_n;
            pend2 <= pend2_n;
            fcnt  <= fcnt_n;
            phase <= phase_n;
            row_q <= row_n;
            r_q   <= r_n;
            g_q   <= g_n;
            fd_q  <= fd_n;
        end
    end

    assign bus.row        = row_q;
    assign bus.r_col      = r_q;
    assign bus.g_col      = g_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_dice_matrix_scan.sv
// tb_dice_matrix_scan
// Drives two dice_matrix_scan instances (DIV=1/BLINK_FRAMES=2 and
// DIV=3/BLINK_FRAMES=3) with the same stimulus and compares every output on
// every cycle against a frame-level reference model.
module tb_dice_matrix_scan;

    localparam int DIV_A = 1;
    localparam int BF_A  = 2;
    localparam int DIV_B = 3;
    localparam int BF_B  = 3;

    logic       clk = 1'b0;
    logic       rst_s = 1'b1;
    logic       load_s = 1'b0;
    logic [3:0] dice1_s = 4'd0;
    logic [3:0] dice2_s = 4'd0;
    logic       blink_s = 1'b0;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    dice_matrix_scan_if ifa ();
    dice_matrix_scan_if ifb ();

    assign ifa.load  = load_s;
    assign ifa.dice1 = dice1_s;
    assign ifa.dice2 = dice2_s;
    assign ifa.blink = blink_s;
    assign ifb.load  = load_s;
    assign ifb.dice1 = dice1_s;
    assign ifb.dice2 = dice2_s;
    assign ifb.blink = blink_s;

    dice_matrix_scan #(.DIV(DIV_A), .BLINK_FRAMES(BF_A)) dut_a (
        .clk (clk),
        .rst (rst_s),
        .bus (ifa.slave)
    );

    dice_matrix_scan #(.DIV(DIV_B), .BLINK_FRAMES(BF_B)) dut_b (
        .clk (clk),
        .rst (rst_s),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset release -> frame/row position; loads
    // are filed under the frame they first appear in; blink phase is derived
    // from the number of wraps seen while blink stayed high.
    logic [8:0] pip_tab [0:15] = '{9'o000, 9'o020, 9'o104, 9'o421, 9'o505,
                                   9'o525, 9'o707, 9'o727, 9'o757, 9'o777,
                                   9'o000, 9'o000, 9'o000, 9'o000, 9'o000, 9'o000};
    logic [7:0] landing [int];
    int         epoch = 0;
    bit         started [2];
    int         tcount [2];
    int         wraps [2];
    logic [3:0] shown1 [2];
    logic [3:0] shown2 [2];
    int         m_idx [2];
    bit         m_blank [2];
    logic [7:0] e_row [2];
    logic [7:0] e_rc [2];
    logic [7:0] e_gc [2];
    logic [7:0] e_fd [2];

    function automatic void step_model(int k);
        int d, bf, p, f, ix, key;
        bit newf, dbl;
        logic [2:0] dots;
        logic [7:0] rc, gc;
        d  = (k == 0) ? DIV_A : DIV_B;
        bf = (k == 0) ? BF_A : BF_B;
        if (rst_s) begin
            started[k] = 1'b0;
            tcount[k]  = 0;
            wraps[k]   = 0;
            shown1[k]  = 4'd0;
            shown2[k]  = 4'd0;
            m_idx[k]   = 0;
            m_blank[k] = 1'b0;
            e_row[k]   = 8'hFF;
            e_rc[k]    = 8'h00;
            e_gc[k]    = 8'h00;
            e_fd[k]    = 8'h00;
            return;
        end
        if (!started[k]) begin
            started[k] = 1'b1;
            tcount[k]  = 0;
        end else begin
            tcount[k]++;
        end
        p    = tcount[k] % (8 * d);
        f    = tcount[k] / (8 * d);
        ix   = p / d;
        newf = (tcount[k] > 0) && (p == 0);
        if (load_s) begin
            key = (epoch * 2 + k) * 100000 + (newf ? f : f + 1);
            landing[key] = {dice1_s, dice2_s};
        end
        if (newf) begin
            key = (epoch * 2 + k) * 100000 + f;
            if (landing.exists(key)) {shown1[k], shown2[k]} = landing[key];
        end
        if (!blink_s) wraps[k] = 0;
        else if (newf) wraps[k]++;
        m_blank[k] = blink_s && (((wraps[k] / bf) % 2) == 1);

        dbl = (shown1[k] == shown2[k]) && (shown1[k] >= 1) && (shown1[k] <= 9);
        rc = 8'h00;
        gc = 8'h00;
        if (ix <= 2) begin
            dots = 3'((pip_tab[shown1[k]] >> (3 * (2 - ix))) & 9'o7);
            rc = {5'b0, dots};
            if (dbl) gc = {5'b0, dots};
        end else if (ix >= 5) begin
            dots = 3'((pip_tab[shown2[k]] >> (3 * (7 - ix))) & 9'o7);
            gc = {dots, 5'b0};
            if (dbl) rc = {dots, 5'b0};
        end
        if (m_blank[k]) begin
            rc = 8'h00;
            gc = 8'h00;
        end
        m_idx[k] = ix;
        e_row[k] = 8'hFF & ~(8'd1 << (7 - ix));
        e_rc[k]  = rc;
        e_gc[k]  = gc;
        e_fd[k]  = ((ix == 7) && ((p % d) == d - 1)) ? 8'd1 : 8'd0;
    endfunction

    always @(posedge clk) begin
        if (rst_s) epoch++;
        step_model(0);
        step_model(1);
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("A.row", ifa.row, e_row[0]);
            checkOutput("A.r_col", ifa.r_col, e_rc[0]);
            checkOutput("A.g_col", ifa.g_col, e_gc[0]);
            checkOutput("A.frame_done", {7'b0, ifa.frame_done}, e_fd[0]);
            checkOutput("B.row", ifb.row, e_row[1]);
            checkOutput("B.r_col", ifb.r_col, e_rc[1]);
            checkOutput("B.g_col", ifb.g_col, e_gc[1]);
            checkOutput("B.frame_done", {7'b0, ifb.frame_done}, e_fd[1]);
        end
    end

    // Drive one cycle of inputs: applied now, sampled at the next rising edge.
    task automatic applyStimulus(input logic l, input logic [3:0] a, input logic [3:0] b,
                                 input logic bl, input logic r);
        load_s  = l;
        dice1_s = a;
        dice2_s = b;
        blink_s = bl;
        rst_s   = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, dice1_s, dice2_s, blink_s, 1'b0);
    endtask

    task automatic load_dice(input logic [3:0] a, input logic [3:0] b);
        applyStimulus(1'b1, a, b, blink_s, 1'b0);
    endtask

    // Advance until instance A shows row index target (bounded).
    task automatic wait_idx(input int target);
        int n = 0;
        while (m_idx[0] != target && n < 40) begin
            applyStimulus(1'b0, dice1_s, dice2_s, blink_s, 1'b0);
            n++;
        end
        checkOutput("wait_idx", 8'(m_idx[0]), 8'(target));
    endtask

    function automatic logic [3:0] rand_die();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(1, 9));
    endfunction

    initial begin
        int n;
        logic [3:0] a, b;
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        checking = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd8, 4'd8, 1'b0, 1'b1);
        idle(5);

        load_dice(4'd3, 4'd5);
        idle(60);
        load_dice(4'd4, 4'd4);
        idle(60);
        load_dice(4'd4, 4'd6);
        idle(60);

        wait_idx(3);
        load_dice(4'd9, 4'd9);
        wait_idx(6);
        load_dice(4'd1, 4'd2);
        idle(30);

        wait_idx(7);
        load_dice(4'd7, 4'd7);
        idle(30);

        wait_idx(3);
        load_dice(4'd11, 4'd2);
        idle(20);

        load_dice(4'd2, 4'd2);
        blink_s = 1'b1;
        idle(100);
        n = 0;
        while (!m_blank[0] && n < 40) begin
            idle(1);
            n++;
        end
        checkOutput("blank_seen", {7'b0, m_blank[0]}, 8'd1);
        wait_idx(2);
        blink_s = 1'b0;
        idle(12);

        wait_idx(5);
        applyStimulus(1'b0, dice1_s, dice2_s, 1'b0, 1'b1);
        idle(20);
        load_dice(4'd6, 4'd6);
        idle(3);
        applyStimulus(1'b0, dice1_s, dice2_s, 1'b0, 1'b1);
        applyStimulus(1'b0, dice1_s, dice2_s, 1'b0, 1'b1);
        applyStimulus(1'b0, dice1_s, dice2_s, 1'b0, 1'b1);
        idle(30);

        for (int i = 0; i < 1500; i++) begin
            a = rand_die();
            b = ($urandom_range(0, 2) == 0) ? a : rand_die();
            if ($urandom_range(0, 99) == 0) blink_s = ~blink_s;
            applyStimulus(($urandom_range(0, 5) == 0), a, b, blink_s,
                          ($urandom_range(0, 399) == 0));
        end
        idle(10);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
